// File: rtl/fetch_prefetch_queue_if.sv
// Fetch-stage bus bundle: instruction-memory request/response, branch redirect and decode handoff.
// master = fetch unit side, slave = memory/decode/branch environment side.
interface fetch_prefetch_queue_if;
   logic        imem_req_valid;
   logic        imem_req_ready;
   logic [31:0] imem_req_addr;
   logic        imem_resp_valid;
   logic [31:0] imem_resp_data;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        dec_valid;
   logic        dec_ready;
   logic [31:0] dec_instr;
   logic [31:0] dec_pc;

   modport master (
      output imem_req_valid, imem_req_addr, dec_valid, dec_instr, dec_pc,
      input  imem_req_ready, imem_resp_valid, imem_resp_data, redirect_valid, redirect_pc, dec_ready
   );
   modport slave (
      input  imem_req_valid, imem_req_addr, dec_valid, dec_instr, dec_pc,
      output imem_req_ready, imem_resp_valid, imem_resp_data, redirect_valid, redirect_pc, dec_ready
   );
endinterface

// File: rtl/fetch_prefetch_queue.sv
// Sequential-PC instruction prefetcher with credit-limited issue, pc-tag queue and decode FIFO.
// Define FETCH_PERF_EN to add perf_fetched/perf_dropped event counters.
module fetch_prefetch_queue #(
   parameter int          DEPTH    = 4,
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic                   clk,
   input  logic                   rst,
   fetch_prefetch_queue_if.master bus
`ifdef FETCH_PERF_EN
   ,
   output logic [31:0]            perf_fetched,
   output logic [31:0]            perf_dropped
`endif
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam logic [CW:0] DEPTH_S = (CW+1)'(DEPTH);
   localparam logic [0:0] S_FETCH = 1'b0;
   localparam logic [0:0] S_FLUSH = 1'b1;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
   } entry_t;

   logic [0:0]    state, state_nxt;
   logic [31:0]   fetch_pc;
   logic [CW-1:0] inflight, inflight_nxt, count;
   logic [31:0]   tag_q [DEPTH];
   logic [AW-1:0] tag_wp, tag_rp;
   entry_t        fifo_q [DEPTH];
   logic [AW-1:0] f_wp, f_rp;
   logic [CW:0]   credit_sum;
   logic          req_fire, resp_keep, resp_drop, push, pop;

   // Credit covers both words still in memory and words already buffered.
   assign credit_sum         = {1'b0, inflight} + {1'b0, count};
   assign bus.imem_req_valid = !rst && (state == S_FETCH) && (credit_sum < DEPTH_S) && !bus.redirect_valid;
   assign bus.imem_req_addr  = fetch_pc;

   assign req_fire  = bus.imem_req_valid && bus.imem_req_ready;
   assign resp_keep = bus.imem_resp_valid && (state == S_FETCH) && !bus.redirect_valid;
   assign resp_drop = bus.imem_resp_valid && !resp_keep;
   assign push      = resp_keep;
   assign pop       = bus.dec_valid && bus.dec_ready;

   assign bus.dec_valid = (count != '0);
   assign bus.dec_instr = bus.dec_valid ? fifo_q[f_rp].instr : 32'h0;
   assign bus.dec_pc    = bus.dec_valid ? fifo_q[f_rp].pc    : 32'h0;

   // Every response retires one outstanding request, whether kept or dropped.
   assign inflight_nxt = inflight + CW'(req_fire) - CW'(bus.imem_resp_valid);

   always_comb begin
      state_nxt = S_FETCH;
      if (bus.redirect_valid || state == S_FLUSH)
         state_nxt = (inflight_nxt != '0) ? S_FLUSH : S_FETCH;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= S_FETCH;
         fetch_pc <= RESET_PC;
         inflight <= '0;
         count    <= '0;
         tag_wp   <= '0;
         tag_rp   <= '0;
         f_wp     <= '0;
         f_rp     <= '0;
      end else begin
         state    <= state_nxt;
         inflight <= inflight_nxt;
         if (bus.redirect_valid) begin
            fetch_pc <= {bus.redirect_pc[31:2], 2'b00};
            count    <= '0;
            tag_wp   <= '0;
            tag_rp   <= '0;
            f_wp     <= '0;
            f_rp     <= '0;
         end else begin
            if (req_fire) begin
               fetch_pc <= fetch_pc + 32'd4;
               tag_wp   <= tag_wp + AW'(1);
            end
            if (resp_keep) tag_rp <= tag_rp + AW'(1);
            if (push)      f_wp   <= f_wp + AW'(1);
            if (pop)       f_rp   <= f_rp + AW'(1);
            count <= count + CW'(push) - CW'(pop);
         end
      end
   end

   // Storage needs no reset: occupancy is tracked by the pointers and count.
   always_ff @(posedge clk) begin
      if (req_fire) tag_q[tag_wp] <= fetch_pc;
      if (push)     fifo_q[f_wp]  <= '{pc: tag_q[tag_rp], instr: bus.imem_resp_data};
   end

`ifdef FETCH_PERF_EN
   logic [31:0] flushed;
   // Entries still buffered at a redirect are lost, except one consumed by decode that cycle.
   assign flushed = bus.redirect_valid ? (32'(count) - 32'(pop)) : 32'h0;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         perf_fetched <= '0;
         perf_dropped <= '0;
      end else begin
         perf_fetched <= perf_fetched + 32'(push);
         perf_dropped <= perf_dropped + 32'(resp_drop) + flushed;
      end
   end
`endif
endmodule
